// File: rtl/tiny_fpga_pkg.sv
// Shared types and derived-width helpers for the tiny_fpga_grid fabric.
package tiny_fpga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic int sel_w(input int io_in, input int rows);
    return $clog2(io_in + rows);
  endfunction

  function automatic int tile_cfg_w(input int lut_width, input int sel_bits);
    return (1 << lut_width) + lut_width * sel_bits + 1;
  endfunction

  function automatic int out_sel_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int cfg_w(input int rows, input int cols, input int lut_width,
                               input int io_in, input int io_out);
    return rows * cols * tile_cfg_w(lut_width, sel_w(io_in, rows))
           + io_out * out_sel_w(rows, cols);
  endfunction

  function automatic int cfg_beats(input int cfg_bits, input int beat_bits);
    return (cfg_bits + beat_bits - 1) / beat_bits;
  endfunction

  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/tiny_fpga_grid_if.sv
// AXI-stream beat bus used to deliver the fabric bitstream.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tiny_fpga_tile.sv
// One LUT tile: per-input source select, LUT lookup and optional output register.
module tiny_fpga_tile #(
  parameter int LUT_WIDTH = 4,
  parameter int SEL_W     = 3,
  parameter int SRC_W     = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_run,
  input  logic [(1 << LUT_WIDTH)-1:0]  i_lut,
  input  logic [LUT_WIDTH*SEL_W-1:0]   i_sel,
  input  logic                         i_ff_en,
  input  logic [SRC_W-1:0]             i_src,
  output logic                         o_out
);

  logic [LUT_WIDTH-1:0] w_idx;
  logic [SEL_W-1:0]     w_s;
  logic                 w_comb;
  logic                 r_q;

  // Select values at or beyond SRC_W match no source and read as 0.
  always_comb begin
    w_idx = '0;
    w_s   = '0;
    for (int unsigned i = 0; i < LUT_WIDTH; i++) begin
      w_s = i_sel[i*SEL_W +: SEL_W];
      for (int unsigned j = 0; j < SRC_W; j++) begin
        if (w_s == SEL_W'(j)) w_idx[i] = i_src[j];
      end
    end
  end

  assign w_comb = i_lut[w_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst)      r_q <= 1'b0;
    else if (i_run) r_q <= w_comb;
  end

  assign o_out = i_ff_en ? r_q : w_comb;

endmodule

// File: rtl/tiny_fpga_grid.sv
// ROWS x COLS feed-forward LUT fabric loaded from an AXI-stream bitstream.
// Define TINY_FPGA_CFG_CHECK_EN to enable tlast framing checks and cfg_error.
module tiny_fpga_grid
  import tiny_fpga_pkg::*;
#(
  parameter int ROWS                 = 2,
  parameter int COLS                 = 2,
  parameter int LUT_WIDTH            = 4,
  parameter int IO_INPUT_WIDTH       = 4,
  parameter int IO_OUTPUT_WIDTH      = 4,
  parameter int BITSTREAM_DATA_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg,
  axi_stream_if.slave                cfg_bitstream,
  output logic                       cfg_ready,
  output logic                       cfg_error,
  input  logic                       run,
  input  logic [IO_INPUT_WIDTH-1:0]  run_in,
  output logic [IO_OUTPUT_WIDTH-1:0] run_out
);

  localparam int SEL_W      = sel_w(IO_INPUT_WIDTH, ROWS);
  localparam int TILE_CFG_W = tile_cfg_w(LUT_WIDTH, SEL_W);
  localparam int OUT_SEL_W  = out_sel_w(ROWS, COLS);
  localparam int CFG_W      = cfg_w(ROWS, COLS, LUT_WIDTH, IO_INPUT_WIDTH, IO_OUTPUT_WIDTH);
  localparam int BW         = BITSTREAM_DATA_WIDTH;
  localparam int CFG_BEATS  = cfg_beats(CFG_W, BW);
  localparam int SR_W       = CFG_BEATS * BW;
  localparam int CNT_W      = cnt_w(CFG_BEATS);
  localparam int NT         = ROWS * COLS;
  localparam int SRC_W      = IO_INPUT_WIDTH + ROWS;
  localparam int LUT_N      = 1 << LUT_WIDTH;
  localparam int OSEL_BASE  = NT * TILE_CFG_W;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_beat;
  logic [SR_W-1:0]      r_sr;
  logic                 r_cfg_ready;
  logic                 w_hs;
  logic                 w_clear;
  logic                 w_last_beat;
  logic                 w_done;
  logic                 w_run;
  logic                 w_tile_rst;
  logic [CFG_W-1:0]     w_cfg;
  logic [NT-1:0]        w_tile_out;
  logic [IO_OUTPUT_WIDTH-1:0] w_fab_out;
  logic [OUT_SEL_W-1:0] w_osel;
`ifdef TINY_FPGA_CFG_CHECK_EN
  logic                 w_frame_err;
  logic                 r_cfg_error;
`endif

  assign w_hs        = (r_state == CFG) && cfg_bitstream.tvalid;
  assign w_last_beat = (r_beat == CNT_W'(CFG_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // cfg is checked before run so a simultaneous request always starts a load.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_done  = 1'b0;
`ifdef TINY_FPGA_CFG_CHECK_EN
    w_frame_err = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (cfg) begin
          w_next  = CFG;
          w_clear = 1'b1;
        end else if (run && r_cfg_ready) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (cfg) begin
          w_next  = CFG;
          w_clear = 1'b1;
        end else if (!run) begin
          w_next = IDLE;
        end
      end
      CFG: begin
        if (w_hs) begin
`ifdef TINY_FPGA_CFG_CHECK_EN
          if (cfg_bitstream.tlast != w_last_beat) begin
            w_frame_err = 1'b1;
            w_next      = IDLE;
          end else if (w_last_beat) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
`else
          if (w_last_beat) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Beats enter at the top and drift toward the LSB, so the first beat ends at bit 0.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_beat      <= '0;
      r_sr        <= '0;
      r_cfg_ready <= 1'b0;
    end else if (w_hs) begin
      r_beat <= r_beat + 1'b1;
      r_sr   <= (r_sr >> BW) | (SR_W'(cfg_bitstream.tdata) << (SR_W - BW));
      if (w_done) r_cfg_ready <= 1'b1;
    end
  end

`ifdef TINY_FPGA_CFG_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || w_clear)   r_cfg_error <= 1'b0;
    else if (w_frame_err) r_cfg_error <= 1'b1;
  end
  assign cfg_error = r_cfg_error;
`else
  assign cfg_error = 1'b0;
`endif

  assign cfg_ready            = r_cfg_ready;
  assign cfg_bitstream.tready = (r_state == CFG);
  assign w_cfg                = r_sr[CFG_W-1:0];
  assign w_run                = (r_state == RUN);
  assign w_tile_rst           = rst | w_clear;

  // Per-column signals live inside the generate block so column c only sees column c-1.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS-1:0]  w_col;
    logic [SRC_W-1:0] w_src;

    if (c == 0) begin : g_first
      assign w_src = {{ROWS{1'b0}}, run_in};
    end else begin : g_next
      assign w_src = {g_col[c-1].w_col, run_in};
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int T = r + c * ROWS;
      localparam int B = T * TILE_CFG_W;

      tiny_fpga_tile #(
        .LUT_WIDTH (LUT_WIDTH),
        .SEL_W     (SEL_W),
        .SRC_W     (SRC_W)
      ) u_tile (
        .i_clk   (clk),
        .i_rst   (w_tile_rst),
        .i_run   (w_run),
        .i_lut   (w_cfg[B +: LUT_N]),
        .i_sel   (w_cfg[B + LUT_N +: LUT_WIDTH * SEL_W]),
        .i_ff_en (w_cfg[B + LUT_N + LUT_WIDTH * SEL_W]),
        .i_src   (w_src),
        .o_out   (w_col[r])
      );
    end

    assign w_tile_out[c*ROWS +: ROWS] = w_col;
  end

  always_comb begin
    w_fab_out = '0;
    w_osel    = '0;
    for (int unsigned k = 0; k < IO_OUTPUT_WIDTH; k++) begin
      w_osel = w_cfg[OSEL_BASE + k*OUT_SEL_W +: OUT_SEL_W];
      for (int unsigned t = 0; t < NT; t++) begin
        if (w_osel == OUT_SEL_W'(t)) w_fab_out[k] = w_tile_out[t];
      end
    end
  end

  assign run_out = w_run ? w_fab_out : '0;

endmodule

// File: tb/tb_tiny_fpga_grid.sv
module tb_tiny_fpga_grid;

  typedef struct {
    int         dut;
    int         kind;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cfg0, cfg1, run0, run1;
  logic [3:0] run_in0, run_in1, out0, out1;
  logic       ready0, err0, ready1, err1;

  exp_t       q[$];
  exp_t       e;
  logic [3:0] act;
  int         n_checks = 0;
  int         n_fail   = 0;

  logic [123:0] cfgA, cfgB;
  logic [127:0] v8;
  logic [3:0]   vin[6], vexp[6], fin[4], fexp[4];

  axi_stream_if #(.DATA_WIDTH(1)) bs0 ();
  axi_stream_if #(.DATA_WIDTH(8)) bs1 ();

  tiny_fpga_grid #(
    .ROWS(2), .COLS(2), .LUT_WIDTH(4), .IO_INPUT_WIDTH(4),
    .IO_OUTPUT_WIDTH(4), .BITSTREAM_DATA_WIDTH(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .cfg(cfg0), .cfg_bitstream(bs0),
    .cfg_ready(ready0), .cfg_error(err0), .run(run0),
    .run_in(run_in0), .run_out(out0)
  );

  tiny_fpga_grid #(
    .ROWS(2), .COLS(2), .LUT_WIDTH(4), .IO_INPUT_WIDTH(4),
    .IO_OUTPUT_WIDTH(4), .BITSTREAM_DATA_WIDTH(8)
  ) u_dut1 (
    .clk(clk), .rst(rst), .cfg(cfg1), .cfg_bitstream(bs1),
    .cfg_ready(ready1), .cfg_error(err1), .run(run1),
    .run_in(run_in1), .run_out(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] observe(input int d, input int k);
    if (d == 0) begin
      case (k)
        0:       return {3'b000, ready0};
        1:       return {3'b000, err0};
        2:       return {3'b000, bs0.tready};
        default: return out0;
      endcase
    end else begin
      case (k)
        0:       return {3'b000, ready1};
        1:       return {3'b000, err1};
        2:       return {3'b000, bs1.tready};
        default: return out1;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = observe(e.dut, e.kind);
      n_checks++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: dut%0d got %b expected %b", e.name, e.dut, act, e.val);
      end
    end
  end

  function automatic void push(input int d, input int k, input logic [3:0] v, input string n);
    exp_t x;
    x.dut = d; x.kind = k; x.val = v; x.name = n;
    q.push_back(x);
  endfunction

  function automatic void chk(input int d, input logic r, input logic er, input logic t,
                              input logic [3:0] o, input string n);
    push(d, 0, {3'b000, r},  {n, "_ready"});
    push(d, 1, {3'b000, er}, {n, "_error"});
    push(d, 2, {3'b000, t},  {n, "_tready"});
    push(d, 3, o,            {n, "_out"});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input logic [123:0] v, input int nbeats, input int last_at);
    cfg0 = 1'b1;
    tick();
    cfg0 = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bs0.tdata  = v[i];
      bs0.tvalid = 1'b1;
      bs0.tlast  = (i == last_at);
      if (i == 0) begin
        push(0, 2, 4'd1, "load0_tready_rise");
        push(0, 0, 4'd0, "load0_ready_cleared");
        push(0, 1, 4'd0, "load0_error_cleared");
      end
      if (i == nbeats - 1) push(0, 0, 4'd0, "load0_ready_before_last");
      tick();
    end
    bs0.tvalid = 1'b0;
    bs0.tlast  = 1'b0;
    bs0.tdata  = '0;
  endtask

  task automatic load1(input logic [127:0] v);
    cfg1 = 1'b1;
    tick();
    cfg1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      bs1.tdata  = v[j*8 +: 8];
      bs1.tvalid = 1'b1;
      bs1.tlast  = (j == 15);
      if (j == 0)  push(1, 2, 4'd1, "load1_tready_rise");
      if (j == 15) push(1, 0, 4'd0, "load1_ready_before_last");
      tick();
    end
    bs1.tvalid = 1'b0;
    bs1.tlast  = 1'b0;
    bs1.tdata  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfgA = '0;
    cfgA[15:0]    = 16'h8888; cfgA[18:16]  = 3'd0; cfgA[21:19]  = 3'd1;
    cfgA[44:29]   = 16'h6666; cfgA[47:45]  = 3'd2; cfgA[50:48]  = 3'd3;
    cfgA[73:58]   = 16'hEEEE; cfgA[76:74]  = 3'd4; cfgA[79:77]  = 3'd5;
    cfgA[102:87]  = 16'h8888; cfgA[105:103] = 3'd4; cfgA[108:106] = 3'd7;
    cfgA[117:116] = 2'd0; cfgA[119:118] = 2'd1; cfgA[121:120] = 2'd2; cfgA[123:122] = 2'd3;
    cfgB = cfgA;
    cfgB[28] = 1'b1;
    v8 = {4'hF, cfgA};

    vin  = '{4'b0011, 4'b0001, 4'b0100, 4'b1101, 4'b1000, 4'b1111};
    vexp = '{4'b0101, 4'b0000, 4'b0110, 4'b0000, 4'b0110, 4'b0101};
    fin  = '{4'b0000, 4'b0011, 4'b0000, 4'b0011};
    fexp = '{4'b0101, 4'b0000, 4'b0101, 4'b0000};

    rst = 1'b1; cfg0 = 1'b0; cfg1 = 1'b0; run0 = 1'b1; run1 = 1'b1;
    run_in0 = 4'hF; run_in1 = 4'hF;
    bs0.tdata = '0; bs0.tvalid = 1'b0; bs0.tlast = 1'b0;
    bs1.tdata = '0; bs1.tvalid = 1'b0; bs1.tlast = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    n_checks++;
    if (ready0 !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_ready0: got %b expected 0", ready0);
    end
    n_checks++;
    if (bs0.tready !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_reset_tready0: got %b expected 0", bs0.tready);
    end
    n_checks++;
    if (out0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL direct_reset_out0: got %b expected 0000", out0);
    end
    chk(0, 1'b0, 1'b0, 1'b0, 4'b0000, "reset0");
    chk(1, 1'b0, 1'b0, 1'b0, 4'b0000, "reset1");
    tick();
    chk(0, 1'b0, 1'b0, 1'b0, 4'b0000, "run_ignored");
    run0 = 1'b0; run1 = 1'b0;

    load0(cfgA, 124, 123);
    n_checks++;
    if (ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_loadA_ready0: got %b expected 1", ready0);
    end
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "loadA_done");
    run0 = 1'b1;
    run_in0 = vin[0];
    tick();
    push(0, 3, vexp[0], "runA_0");
    for (int i = 1; i < 6; i++) begin
      tick();
      run_in0 = vin[i];
      push(0, 3, vexp[i], "runA_n");
    end
    run0 = 1'b0;
    tick();
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "runA_exit");

    load0(cfgB, 124, 123);
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "loadB_done");
    run0 = 1'b1;
    run_in0 = 4'b0011;
    tick();
    push(0, 3, 4'b0000, "ffB_first");
    for (int i = 0; i < 4; i++) begin
      tick();
      run_in0 = fin[i];
      push(0, 3, fexp[i], "ffB_seq");
    end
    run0 = 1'b0;
    tick();
    push(0, 3, 4'b0000, "ffB_idle");
    run_in0 = 4'b0000;
    tick();
    run0 = 1'b1;
    tick();
    push(0, 3, 4'b0101, "ffB_hold");
    run0 = 1'b0;
    tick();

    run0 = 1'b1;
    load0(cfgA, 124, 123);
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "cfgwins_done");
    run_in0 = 4'b0011;
    tick();
    push(0, 3, 4'b0101, "cfgwins_run");
    run0 = 1'b0;
    tick();

`ifdef TINY_FPGA_CFG_CHECK_EN
    load0(cfgA, 51, 50);
    chk(0, 1'b0, 1'b1, 1'b0, 4'b0000, "frame_early");
    load0(cfgA, 124, -1);
    chk(0, 1'b0, 1'b1, 1'b0, 4'b0000, "frame_missing");
    load0(cfgA, 124, 123);
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "frame_recover");
`else
    load0(cfgA, 124, 50);
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "tlast_ignored");
`endif

    load0(cfgA, 61, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(0, 1'b0, 1'b0, 1'b0, 4'b0000, "rst_midload");
    tick();
    push(0, 2, 4'd0, "rst_stays_idle");
    load0(cfgA, 124, 123);
    chk(0, 1'b1, 1'b0, 1'b0, 4'b0000, "reload_done");
    run0 = 1'b1;
    run_in0 = 4'b0100;
    tick();
    push(0, 3, 4'b0110, "reload_run");
    run0 = 1'b0;
    tick();

    load1(v8);
    chk(1, 1'b1, 1'b0, 1'b0, 4'b0000, "bw8_done");
    run1 = 1'b1;
    run_in1 = 4'b0011;
    tick();
    push(1, 3, 4'b0101, "bw8_run_a");
    tick();
    run_in1 = 4'b0100;
    push(1, 3, 4'b0110, "bw8_run_b");
    run1 = 1'b0;
    tick();
    push(1, 3, 4'b0000, "bw8_idle");

    repeat (3) tick();
    n_checks++;
    if (ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_bw8_ready1_held: got %b expected 1", ready1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
